rr_mux_reg: RTL and testbench

Parametrised, registered N:1 channel multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output. It replaces hard-wired 4:1 select muxing wherever several producers share one consumer. It picks fairly among requesting channels, so no select input is needed. It holds the chosen word in an output register until the consumer accepts it.

---
 rtl/rr_mux_reg_if.sv | 27 ++
 rtl/rr_mux_reg.sv | 89 ++++++++
 tb/tb_rr_mux_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rr_mux_reg_if.sv
// rtl/rr_mux_reg_if.sv - handshake bundle between producers, rr_mux_reg and its consumer
interface rr_mux_reg_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready;

    // Environment side: drives requests and consumer ready, observes grants and output word
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Multiplexer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - registered N:1 round-robin channel multiplexer with valid/ready handshakes
module rr_mux_reg #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_reg_if.slave bus
);
    localparam int              CH_W    = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_ptr;

    logic              w_load_en;
    logic              w_fire;
    logic              w_hi_any;
    logic              w_lo_any;
    logic [CH_W-1:0]   w_hi_gnt;
    logic [CH_W-1:0]   w_lo_gnt;
    logic [DATA_W-1:0] w_hi_data;
    logic [DATA_W-1:0] w_lo_data;
    logic [CH_W-1:0]   w_gnt;
    logic [DATA_W-1:0] w_gnt_data;
    logic [NUM_CH-1:0] w_ready;

    // Register can take a word when empty or being drained this cycle
    assign w_load_en = !r_out_valid || bus.out_ready;

    // Two-pass priority: lowest requester at or above r_ptr, else lowest requester overall (the wrap)
    always_comb begin
        w_hi_any  = 1'b0;
        w_lo_any  = 1'b0;
        w_hi_gnt  = '0;
        w_lo_gnt  = '0;
        w_hi_data = '0;
        w_lo_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                w_lo_any  = 1'b1;
                w_lo_gnt  = CH_W'(i);
                w_lo_data = bus.in_data[i*DATA_W +: DATA_W];
                if (CH_W'(i) >= r_ptr) begin
                    w_hi_any  = 1'b1;
                    w_hi_gnt  = CH_W'(i);
                    w_hi_data = bus.in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_gnt      = w_hi_any ? w_hi_gnt  : w_lo_gnt;
    assign w_gnt_data = w_hi_any ? w_hi_data : w_lo_data;
    // Gating with rst_n keeps every in_ready low while reset is held
    assign w_fire     = rst_n && w_load_en && w_lo_any;

    // One-hot accept towards the winning producer only
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ready[i] = w_fire && (w_gnt == CH_W'(i));
        end
    end

    // Output register and pointer; pointer advances only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt;
            r_ptr       <= (w_gnt == LAST_CH) ? '0 : w_gnt + 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - self-checking bench for rr_mux_reg (4-channel and 3-channel instances)
module tb_rr_mux_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    rr_mux_reg_if #(.NUM_CH(4), .DATA_W(4)) if4 ();
    rr_mux_reg_if #(.NUM_CH(3), .DATA_W(4)) if3 ();

    rr_mux_reg #(.NUM_CH(4), .DATA_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    rr_mux_reg #(.NUM_CH(3), .DATA_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_por();
        rst_n = 1'b0;
        if4.in_valid = '0; if4.in_data = 16'hDCBA; if4.out_ready = 1'b0;
        if3.in_valid = '0; if3.in_data = 12'h321;  if3.out_ready = 1'b0;
        step(); step();
        if4.in_valid = 4'b1111;
        if4.out_ready = 1'b1;
        #1;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %0b expected 0", if4.out_valid); end
        checks++; if (if4.out_data !== 4'h0) begin errors++; $display("FAIL por_data: got %0h expected 0", if4.out_data); end
        checks++; if (if4.out_ch !== 2'd0) begin errors++; $display("FAIL por_ch: got %0d expected 0", if4.out_ch); end
        checks++; if (if4.in_ready !== 4'b0000) begin errors++; $display("FAIL por_in_ready: got %b expected 0000", if4.in_ready); end
        checks++; if (dut4.r_ptr !== 2'd0) begin errors++; $display("FAIL por_ptr: got %0d expected 0", dut4.r_ptr); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        exp_q.push_back('{2'd0, 4'hA});
        exp_q.push_back('{2'd1, 4'hB});
        exp_q.push_back('{2'd2, 4'hC});
        exp_q.push_back('{2'd3, 4'hD});
        exp_q.push_back('{2'd0, 4'hA});
        for (int n = 0; n < 5; n++) begin
            step();
            e = exp_q.pop_front();
            checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b expected 1", n, if4.out_valid); end
            checks++; if (if4.out_data !== e.data) begin errors++; $display("FAIL rr_data[%0d]: got %0h expected %0h", n, if4.out_data, e.data); end
            checks++; if (if4.out_ch !== e.ch) begin errors++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", n, if4.out_ch, e.ch); end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", if4.out_valid); end
        checks++; if (if4.out_data !== 4'h0) begin errors++; $display("FAIL rst_data: got %0h expected 0", if4.out_data); end
        checks++; if (if4.out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d expected 0", if4.out_ch); end
        checks++; if (dut4.r_ptr !== 2'd0) begin errors++; $display("FAIL rst_ptr: got %0d expected 0", dut4.r_ptr); end
        checks++; if (if4.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b expected 0000", if4.in_ready); end
        step();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %0b expected 0", if4.out_valid); end
        rst_n = 1'b1;
        exp_q.push_back('{2'd0, 4'hA});
        step();
        e = exp_q.pop_front();
        checks++; if (if4.out_ch !== e.ch || if4.out_data !== e.data || if4.out_valid !== 1'b1)
            begin errors++; $display("FAIL rst_first_grant: got ch=%0d data=%0h expected ch=%0d data=%0h", if4.out_ch, if4.out_data, e.ch, e.data); end
    endtask

    task automatic test_pointer_skip();
        if4.in_valid = 4'b0010;
        exp_q.push_back('{2'd1, 4'hB});
        step();
        e = exp_q.pop_front();
        checks++; if (if4.out_ch !== e.ch || if4.out_data !== e.data) begin errors++; $display("FAIL skip_setup: got ch=%0d data=%0h expected ch=%0d data=%0h", if4.out_ch, if4.out_data, e.ch, e.data); end
        checks++; if (dut4.r_ptr !== 2'd2) begin errors++; $display("FAIL skip_ptr2: got %0d expected 2", dut4.r_ptr); end
        if4.in_valid = 4'b0011;
        #1;
        checks++; if (if4.in_ready !== 4'b0001) begin errors++; $display("FAIL skip_in_ready: got %b expected 0001", if4.in_ready); end
        exp_q.push_back('{2'd0, 4'hA});
        exp_q.push_back('{2'd1, 4'hB});
        for (int n = 0; n < 2; n++) begin
            step();
            e = exp_q.pop_front();
            checks++; if (if4.out_ch !== e.ch || if4.out_data !== e.data) begin errors++; $display("FAIL skip_grant[%0d]: got ch=%0d data=%0h expected ch=%0d data=%0h", n, if4.out_ch, if4.out_data, e.ch, e.data); end
            checks++; if (dut4.r_ptr !== (n == 0 ? 2'd1 : 2'd2)) begin errors++; $display("FAIL skip_ptr[%0d]: got %0d expected %0d", n, dut4.r_ptr, (n == 0 ? 1 : 2)); end
        end
    endtask

    task automatic test_backpressure();
        if4.out_ready = 1'b0;
        if4.in_valid = 4'b0100;
        #1;
        checks++; if (if4.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready0: got %b expected 0000", if4.in_ready); end
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 4'hB || if4.out_ch !== 2'd1 || if4.in_ready !== 4'b0000)
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%0b data=%0h ch=%0d rdy=%b expected v=1 data=b ch=1 rdy=0000", n, if4.out_valid, if4.out_data, if4.out_ch, if4.in_ready); end
        end
        if4.out_ready = 1'b1;
        #1;
        checks++; if (if4.in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected 0100", if4.in_ready); end
        exp_q.push_back('{2'd2, 4'hC});
        step();
        e = exp_q.pop_front();
        checks++; if (if4.out_ch !== e.ch || if4.out_data !== e.data || if4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_grant: got ch=%0d data=%0h expected ch=%0d data=%0h", if4.out_ch, if4.out_data, e.ch, e.data); end
    endtask

    task automatic test_drain();
        if4.in_valid = 4'b0000;
        step();
        checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b expected 0", if4.out_valid); end
        checks++; if (if4.out_data !== 4'hC || if4.out_ch !== 2'd2) begin errors++; $display("FAIL drain_hold: got data=%0h ch=%0d expected data=c ch=2", if4.out_data, if4.out_ch); end
        step();
        checks++; if (if4.out_valid !== 1'b0 || dut4.r_ptr !== 2'd3) begin errors++; $display("FAIL idle_hold: got v=%0b ptr=%0d expected v=0 ptr=3", if4.out_valid, dut4.r_ptr); end
    endtask

    task automatic test_wrap3();
        logic [1:0] exp_ptr [4];
        exp_ptr[0] = 2'd1; exp_ptr[1] = 2'd2; exp_ptr[2] = 2'd0; exp_ptr[3] = 2'd1;
        if3.out_ready = 1'b1;
        if3.in_valid = 3'b111;
        exp_q.push_back('{2'd0, 4'h1});
        exp_q.push_back('{2'd1, 4'h2});
        exp_q.push_back('{2'd2, 4'h3});
        exp_q.push_back('{2'd0, 4'h1});
        for (int n = 0; n < 4; n++) begin
            step();
            e = exp_q.pop_front();
            checks++; if (if3.out_ch !== e.ch || if3.out_data !== e.data || if3.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_grant[%0d]: got ch=%0d data=%0h expected ch=%0d data=%0h", n, if3.out_ch, if3.out_data, e.ch, e.data); end
            checks++; if (dut3.r_ptr !== exp_ptr[n]) begin errors++; $display("FAIL wrap_ptr[%0d]: got %0d expected %0d", n, dut3.r_ptr, exp_ptr[n]); end
        end
    endtask

    initial begin
        test_por();
        test_round_robin();
        test_reset_mid();
        test_pointer_skip();
        test_backpressure();
        test_drain();
        test_wrap3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
